wb_excp_ctrl: RTL

- Writeback-stage exception/interrupt commit controller: the producer side of the CSR file's hardware-access port.
- Resolves the final event for the instruction in WB: interrupt, synchronous exception carried down the pipe, ertn, or none.
- Issues single-cycle wb_ex / ertn_flush pulses to the CSR file, flushes the pipeline, and hands a redirect PC (EENTRY or ERA) to IF with a valid/ready handshake.

---
 rtl/wb_excp_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/wb_excp_ctrl.sv
// wb_excp_ctrl: writeback-stage exception/interrupt commit controller.
// Resolves the WB event, pulses the CSR file, flushes the pipe and redirects IF.
module wb_excp_ctrl #(
    parameter logic [5:0]  ECODE_INT = 6'h0,
    parameter logic [12:0] INT_MASK  = 13'h1bff
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ex_in,
    input  logic [5:0]  wb_ecode_in,
    input  logic [8:0]  wb_esubcode_in,
    input  logic [31:0] wb_vaddr_in,
    input  logic        wb_is_ertn,
    input  logic        csr_crmd_ie,
    input  logic [12:0] csr_estat_is,
    input  logic [12:0] csr_ecfg_lie,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        csr_wb_ex,
    output logic [5:0]  csr_wb_ecode,
    output logic [8:0]  csr_wb_esubcode,
    output logic [31:0] csr_wb_pc,
    output logic [31:0] csr_wb_vaddr,
    output logic        csr_ertn_flush,
    output logic        wb_accept,
    output logic        wb_commit_ok,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic [31:0] ex_count
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
    state_t state, state_nxt;
    logic int_pending, kind_ertn, ev_int, ev_ex, ev_ertn, ev_any, handshake;

    always_comb begin
        ev_int    = wb_valid & int_pending;
        ev_ex     = wb_valid & ~int_pending & wb_ex_in;
        ev_ertn   = wb_valid & ~int_pending & ~wb_ex_in & wb_is_ertn;
        ev_any    = ev_int | ev_ex | ev_ertn;
        handshake = redirect_valid & redirect_ready;
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = ev_any ? FLUSH : IDLE;
            FLUSH:    state_nxt = REDIRECT;
            REDIRECT: state_nxt = handshake ? IDLE : REDIRECT;
            default:  state_nxt = IDLE;
        endcase
    end

    assign wb_accept    = (state == IDLE);
    assign wb_commit_ok = wb_valid & wb_accept & ~ev_any;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            int_pending     <= 1'b0;
            kind_ertn       <= 1'b0;
            csr_wb_ex       <= 1'b0;
            csr_ertn_flush  <= 1'b0;
            csr_wb_ecode    <= '0;
            csr_wb_esubcode <= '0;
            csr_wb_pc       <= '0;
            csr_wb_vaddr    <= '0;
            pipe_flush      <= 1'b0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            ex_count        <= '0;
        end else begin
            state          <= state_nxt;
            int_pending    <= csr_crmd_ie & |(csr_estat_is & csr_ecfg_lie & INT_MASK);
            csr_wb_ex      <= 1'b0;
            csr_ertn_flush <= 1'b0;
            case (state)
                IDLE: if (ev_any) begin
                    csr_wb_ex       <= ev_int | ev_ex;
                    csr_ertn_flush  <= ev_ertn;
                    csr_wb_ecode    <= ev_int ? ECODE_INT : wb_ecode_in;
                    csr_wb_esubcode <= ev_int ? 9'h0 : wb_esubcode_in;
                    csr_wb_pc       <= wb_pc;
                    csr_wb_vaddr    <= ev_ex ? wb_vaddr_in : csr_wb_vaddr;
                    kind_ertn       <= ev_ertn;
                end
                FLUSH: begin
                    pipe_flush  <= 1'b1;
                    redirect_pc <= kind_ertn ? csr_era : csr_eentry;
                    ex_count    <= kind_ertn ? ex_count : ex_count + 32'd1;
                end
                REDIRECT: begin
                    // valid rises one cycle into REDIRECT and drops right after the handshake
                    redirect_valid <= ~handshake;
                    pipe_flush     <= ~handshake;
                end
                default: ;
            endcase
        end
    end
endmodule
